// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Imported by fetch_ctrl and fetch_skid_buf.
package fetch_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } fetch_ent_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry fall-through skid buffer holding {pc, instr} between ROM and decode.
// Ports: clk, rst_n, flush; in_valid/in_pc/in_instr/in_ready; out_valid/out_ready/out_pc/out_instr.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_instr
);

    fetch_ent_t ent_q [2];
    fetch_ent_t in_ent;
    fetch_ent_t head;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic [1:0] wp;
    logic       pop_s;
    logic       byp;
    logic       wr;

    assign in_ent = '{pc: in_pc, instr: in_instr};

    // An empty buffer passes the arriving word straight through.
    assign byp   = (cnt_q == 2'd0) & in_valid & out_ready;
    assign pop_s = (cnt_q != 2'd0) & out_ready;
    assign wr    = in_valid & ~byp;
    assign cnt_d = cnt_q - {1'b0, pop_s} + {1'b0, wr};
    assign wp    = cnt_q - {1'b0, pop_s};

    // Credit: room for one more word next cycle even if decode stalls.
    assign in_ready = (cnt_d <= 2'd1);

    assign head      = (cnt_q != 2'd0) ? ent_q[0] : in_ent;
    assign out_valid = (cnt_q != 2'd0) | in_valid;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            ent_q[0] <= '{pc: '0, instr: NOP_INSTR};
            ent_q[1] <= '{pc: '0, instr: NOP_INSTR};
        end else begin
            cnt_q <= flush ? 2'd0 : cnt_d;
            if (pop_s) begin
                ent_q[0] <= ent_q[1];
            end
            if (wr) begin
                ent_q[wp[0]] <= in_ent;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM, pairs words with PCs.
// Ports: clk, rst_n, fetch_en, redirect_valid/redirect_pc, rom_addr, rom_instr,
//        out_valid/out_ready/out_instr/out_pc, misalign_err.
// Define FETCH_SKID_EN to insert a 2-entry skid buffer before decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 10,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic              misalign_err
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] resp_pc_q;
    logic            resp_v_q;
    logic            err_q;
    logic            issue;
    logic            hold;
    logic            keep_resp;

`ifdef FETCH_SKID_EN
    logic sk_space;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .in_valid  (resp_v_q),
        .in_pc     (resp_pc_q),
        .in_instr  (rom_instr),
        .in_ready  (sk_space),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr)
    );

    // Every response lands in the buffer; issue waits for buffer room.
    assign hold      = ~sk_space;
    assign keep_resp = 1'b0;
    assign rom_addr  = pc_q[ADDR_W+1:2];
`else
    // Back-pressure holds the response and re-reads the same ROM word.
    assign hold      = resp_v_q & ~out_ready;
    assign keep_resp = hold;
    assign rom_addr  = hold ? resp_pc_q[ADDR_W+1:2] : pc_q[ADDR_W+1:2];
    assign out_valid = resp_v_q;
    assign out_pc    = resp_pc_q;
    assign out_instr = rom_instr;
`endif

    assign misalign_err = err_q;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_en && !hold) begin
                    issue   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN, STALL: begin
                if (hold) begin
                    state_d = STALL;
                end else if (fetch_en) begin
                    issue   = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Redirect squashes everything and restarts from IDLE.
        if (redirect_valid) begin
            issue   = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            resp_v_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (redirect_valid) begin
                pc_q     <= {redirect_pc[PC_W-1:2], 2'b00};
                resp_v_q <= 1'b0;
                if (redirect_pc[1:0] != 2'b00) begin
                    err_q <= 1'b1;
                end
            end else if (issue) begin
                pc_q      <= pc_q + PC_STEP;
                resp_v_q  <= 1'b1;
                resp_pc_q <= pc_q;
            end else if (!keep_resp) begin
                resp_v_q <= 1'b0;
            end
        end
    end

endmodule
